// File: rtl/alarm_sequencer.sv
// Alarm / hourly-chime sequencer feeding the buzzer stage.
// Produces a registered buzzer enable with a 500 ms on/off cadence.
module alarm_sequencer #(
    parameter int HALF_SEC_CYCLES = 12000000,
    parameter int RING_TIMEOUT_S  = 60,
    parameter int SNOOZE_S        = 300,
    parameter int CHIME_BEEPS     = 2
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       sec_tick,
    input  logic [7:0] time_hour,
    input  logic [7:0] time_min,
    input  logic [7:0] time_sec,
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_min,
    input  logic       alarm_en,
    input  logic       chime_en,
    input  logic       key_stop,
    input  logic       key_snooze,
    output logic       Value_en,
    output logic       alarm_ringing,
    output logic       snooze_active
);

    localparam int RW = $clog2(RING_TIMEOUT_S + 1);
    localparam int SW = $clog2(SNOOZE_S + 1);
    localparam int BW = $clog2(CHIME_BEEPS + 1);

    localparam logic [23:0]   PH_LAST   = 24'(HALF_SEC_CYCLES - 1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT_S - 1);
    localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_S);
    localparam logic [SW-1:0] SNZ_ONE   = SW'(1);
    localparam logic [BW-1:0] BEEPS     = BW'(CHIME_BEEPS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RING,
        S_SNOOZE,
        S_CHIME
    } state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] ring_sec_q, ring_sec_d;
    logic [SW-1:0] snz_cnt_q, snz_cnt_d;
    logic [23:0]   ph_cnt_q, ph_cnt_d;
    logic          ph_on_q, ph_on_d;
    logic [BW-1:0] beep_q, beep_d;
    logic [BW-1:0] beep_inc;
    logic          ven_q, ring_q, snz_q;

    logic alarm_hit, hour_hit, ph_last;
    logic go_ring, go_chime, go_rest, advance;

    assign alarm_hit = sec_tick & alarm_en
                     & (time_hour == alarm_hour)
                     & (time_min == alarm_min)
                     & (time_sec == 8'h00);
    assign hour_hit  = sec_tick & chime_en
                     & (time_min == 8'h00)
                     & (time_sec == 8'h00);
    assign ph_last   = (ph_cnt_q == PH_LAST);
    assign beep_inc  = beep_q + 1'b1;

    // Next state, second/beep counters and cadence phase.
    always_comb begin
        state_d    = state_q;
        ring_sec_d = ring_sec_q;
        snz_cnt_d  = snz_cnt_q;
        ph_cnt_d   = ph_cnt_q;
        ph_on_d    = ph_on_q;
        beep_d     = beep_q;
        go_ring    = 1'b0;
        go_chime   = 1'b0;
        go_rest    = 1'b0;
        advance    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (alarm_hit) begin
                    go_ring = 1'b1;
                end else if (hour_hit) begin
                    go_chime = 1'b1;
                end
            end
            S_RING: begin
                if (key_stop || !alarm_en) begin
                    state_d = S_IDLE;
                    go_rest = 1'b1;
                end else if (key_snooze) begin
                    state_d   = S_SNOOZE;
                    snz_cnt_d = SNZ_LOAD;
                    go_rest   = 1'b1;
                end else if (sec_tick && ring_sec_q == RING_LAST) begin
                    state_d = S_IDLE;
                    go_rest = 1'b1;
                end else begin
                    advance = 1'b1;
                    if (sec_tick) begin
                        ring_sec_d = ring_sec_q + 1'b1;
                    end
                end
            end
            S_SNOOZE: begin
                if (key_stop || !alarm_en) begin
                    state_d = S_IDLE;
                    go_rest = 1'b1;
                end else if (sec_tick && snz_cnt_q == SNZ_ONE) begin
                    go_ring = 1'b1;
                end else if (sec_tick && snz_cnt_q != '0) begin
                    snz_cnt_d = snz_cnt_q - 1'b1;
                end
            end
            S_CHIME: begin
                if (key_stop) begin
                    state_d = S_IDLE;
                    go_rest = 1'b1;
                end else if (alarm_hit) begin
                    go_ring = 1'b1;
                end else begin
                    advance = 1'b1;
                    if (ph_last && ph_on_q) begin
                        beep_d = beep_inc;
                        // No trailing off-phase after the last beep.
                        if (beep_inc == BEEPS) begin
                            state_d = S_IDLE;
                            go_rest = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                go_rest = 1'b1;
            end
        endcase

        if (advance) begin
            if (ph_last) begin
                ph_cnt_d = '0;
                ph_on_d  = ~ph_on_q;
            end else begin
                ph_cnt_d = ph_cnt_q + 24'd1;
            end
        end

        if (go_rest) begin
            ph_cnt_d = '0;
            ph_on_d  = 1'b0;
        end

        if (go_ring) begin
            state_d    = S_RING;
            ring_sec_d = '0;
            ph_cnt_d   = '0;
            ph_on_d    = 1'b1;
        end

        if (go_chime) begin
            state_d  = S_CHIME;
            beep_d   = '0;
            ph_cnt_d = '0;
            ph_on_d  = 1'b1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= S_IDLE;
            ring_sec_q <= '0;
            snz_cnt_q  <= '0;
            ph_cnt_q   <= '0;
            ph_on_q    <= 1'b0;
            beep_q     <= '0;
            ven_q      <= 1'b0;
            ring_q     <= 1'b0;
            snz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_sec_q <= ring_sec_d;
            snz_cnt_q  <= snz_cnt_d;
            ph_cnt_q   <= ph_cnt_d;
            ph_on_q    <= ph_on_d;
            beep_q     <= beep_d;
            ven_q      <= ((state_d == S_RING) || (state_d == S_CHIME))
                          && ph_on_d;
            ring_q     <= (state_d == S_RING);
            snz_q      <= (state_d == S_SNOOZE);
        end
    end

    assign Value_en      = ven_q;
    assign alarm_ringing = ring_q;
    assign snooze_active = snz_q;

endmodule
